// File: rtl/dbg_mem_loader_if.sv
// Bundles the byte-stream input and the SoC debug write port of the program loader.
// The master side is the loader; the slave side is the byte source plus debug port.
interface dbg_mem_loader_if #(
    parameter int DATA_W = 32,
    parameter int ADR_W  = 32
);
    logic [7:0]          in_data;
    logic                in_valid;
    logic                in_ready;
    logic                dbg_mem_op;
    logic [DATA_W/8-1:0] dbg_wren;
    logic [ADR_W-1:0]    dbg_adr;
    logic [DATA_W-1:0]   dbg_do;

    modport master (
        input  in_data, in_valid,
        output in_ready, dbg_mem_op, dbg_wren, dbg_adr, dbg_do
    );

    modport slave (
        output in_data, in_valid,
        input  in_ready, dbg_mem_op, dbg_wren, dbg_adr, dbg_do
    );
endinterface

// File: rtl/dbg_mem_loader.sv
// Debug-bus program loader: holds the CPU in reset, packs a byte stream into
// little-endian words, writes them over the debug port, then releases the CPU.
module dbg_mem_loader #(
    parameter int DATA_W      = 32,
    parameter int ADR_W       = 32,
    parameter int LEN_W       = 16,
    parameter int WR_HOLD     = 4,
    parameter int RELEASE_DLY = 2,
    parameter int BOOT_HOLD   = 1
) (
    input  logic                  clk,
    input  logic                  n_reset,
    input  logic                  start,
    input  logic [ADR_W-1:0]      base_adr,
    input  logic [LEN_W-1:0]      len_bytes,
    dbg_mem_loader_if.master      bus,
    output logic                  cpu_n_reset,
    output logic                  busy,
    output logic                  done
);
    localparam int LANES  = DATA_W / 8;
    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int HOLD_W = (WR_HOLD > 1) ? $clog2(WR_HOLD) : 1;
    localparam int REL_W  = (RELEASE_DLY > 1) ? $clog2(RELEASE_DLY) : 1;

    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);
    localparam logic [HOLD_W-1:0] LAST_HOLD = HOLD_W'(WR_HOLD - 1);
    localparam logic [REL_W-1:0]  LAST_REL  = REL_W'(RELEASE_DLY - 1);
    localparam logic [ADR_W-1:0]  ADR_MASK  = ~ADR_W'(LANES - 1);
    localparam logic [ADR_W-1:0]  ADR_STEP  = ADR_W'(LANES);

    typedef enum logic [1:0] {IDLE, COLLECT, WRITE, RELEASE} state_t;

    state_t             state_q;
    state_t             state_d;
    logic [ADR_W-1:0]   adr_q;
    logic [LEN_W-1:0]   remaining_q;
    logic [LANE_W-1:0]  lane_q;
    logic [DATA_W-1:0]  data_q;
    logic [LANES-1:0]   wren_q;
    logic [HOLD_W-1:0]  hold_q;
    logic [REL_W-1:0]   rel_q;
    logic               cpu_n_reset_q;
    logic               done_q;

    logic start_ok;
    logic byte_ok;
    logic word_full;
    logic hold_end;
    logic rel_end;

    // A start seen on the done cycle is deliberately dropped
    assign start_ok  = (state_q == IDLE) && start && !done_q;
    assign byte_ok   = (state_q == COLLECT) && bus.in_valid;
    assign word_full = (lane_q == LAST_LANE) || (remaining_q == LEN_W'(1));
    assign hold_end  = (hold_q == LAST_HOLD);
    assign rel_end   = (rel_q == LAST_REL);

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_ok) state_d = (len_bytes != '0) ? COLLECT : RELEASE;
            COLLECT: if (byte_ok && word_full) state_d = WRITE;
            WRITE:   if (hold_end) state_d = (remaining_q != '0) ? COLLECT : RELEASE;
            RELEASE: if (rel_end) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready   = 1'b0;
        bus.dbg_mem_op = 1'b0;
        bus.dbg_wren   = '0;
        busy           = (state_q != IDLE);
        case (state_q)
            COLLECT: bus.in_ready = 1'b1;
            WRITE: begin
                bus.dbg_mem_op = 1'b1;
                bus.dbg_wren   = wren_q;
            end
            default: ;
        endcase
    end

    assign bus.dbg_adr = adr_q;
    assign bus.dbg_do  = data_q;
    assign cpu_n_reset = cpu_n_reset_q;
    assign done        = done_q;

    // Packer clears at the end of each write so unwritten lanes of a short word read as zero
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            adr_q         <= '0;
            remaining_q   <= '0;
            lane_q        <= '0;
            data_q        <= '0;
            wren_q        <= '0;
            hold_q        <= '0;
            rel_q         <= '0;
            cpu_n_reset_q <= (BOOT_HOLD == 0);
            done_q        <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_ok) begin
                        adr_q         <= base_adr & ADR_MASK;
                        remaining_q   <= len_bytes;
                        cpu_n_reset_q <= 1'b0;
                    end
                end
                COLLECT: begin
                    if (byte_ok) begin
                        for (int k = 0; k < LANES; k++) begin
                            if (lane_q == LANE_W'(k)) begin
                                data_q[8*k +: 8] <= bus.in_data;
                                wren_q[k]        <= 1'b1;
                            end
                        end
                        lane_q      <= lane_q + 1'b1;
                        remaining_q <= remaining_q - 1'b1;
                    end
                end
                WRITE: begin
                    if (hold_end) begin
                        hold_q <= '0;
                        adr_q  <= adr_q + ADR_STEP;
                        data_q <= '0;
                        wren_q <= '0;
                        lane_q <= '0;
                    end else begin
                        hold_q <= hold_q + 1'b1;
                    end
                end
                RELEASE: begin
                    if (rel_end) begin
                        rel_q         <= '0;
                        cpu_n_reset_q <= 1'b1;
                        done_q        <= 1'b1;
                    end else begin
                        rel_q <= rel_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
